regstrb2mem_readback: RTL and testbench

Reads instruction words back out of code memory for host inspection: the opposite direction to the register-strobe-to-code-memory write path. The host loads a start address. The block fetches the 64-bit word and splits it into high and low 32-bit register values. After the host has read both halves, the block auto-advances to the next word. It sits between the code memory's spare read port and the AXI-Lite register file.

---
 rtl/regstrb2mem_readback.sv | 129 ++++++++++++
 tb/tb_regstrb2mem_readback.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regstrb2mem_readback.sv
// regstrb2mem_readback
// Reads 64-bit instruction words back out of code memory and presents them to
// the host as two 32-bit register values. After the host has read both halves,
// the block fetches the next word (address wraps at the top of code memory).
//
// Handshake: readback_valid qualifies inst_high_value/inst_low_value. A read
// strobe is accepted only while readback_valid is high; a read strobe at any
// other time is dropped and sets the sticky readback_underflow flag. The memory
// side is a fixed-latency pipe: code_mem_rd_data is valid exactly RD_LATENCY
// cycles after a code_mem_rd_en pulse, with no back-pressure.
module regstrb2mem_readback #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int CODE_DATA_WIDTH = 64,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [CODE_ADDR_WIDTH-1:0] code_mem_rd_addr,
  output logic                       code_mem_rd_en,
  input  logic [CODE_DATA_WIDTH-1:0] code_mem_rd_data,
  input  logic [CODE_ADDR_WIDTH-1:0] readback_addr_value,
  input  logic                       readback_addr_strobe,
  input  logic                       inst_high_rd_strobe,
  input  logic                       inst_low_rd_strobe,
  output logic [31:0]                inst_high_value,
  output logic [31:0]                inst_low_value,
  output logic                       readback_valid,
  output logic                       readback_underflow,
  input  logic                       control_start,
  output logic [1:0]                 debug_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_ONE = {{(CODE_ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic                  high_done;
  logic                  low_done;
  // Bit i set means a read issued i+1 cycles ago is still live; the top bit
  // marks the cycle in which its data sits on code_mem_rd_data.
  logic [RD_LATENCY-1:0] pipe;
  logic [RD_LATENCY:0]   pipe_shift;
  logic                  pipe_tail;
  logic                  any_rd;
  logic                  high_next;
  logic                  low_next;
  logic                  both_done;

  assign debug_state = state;

  // Derive the consumption flags including strobes arriving this cycle.
  always_comb begin
    pipe_shift = {pipe, code_mem_rd_en};
    pipe_tail  = pipe[RD_LATENCY-1];
    any_rd     = inst_high_rd_strobe | inst_low_rd_strobe;
    high_next  = high_done | inst_high_rd_strobe;
    low_next   = low_done | inst_low_rd_strobe;
    both_done  = (state == ST_VALID) && high_next && low_next;
  end

  // Readback FSM: control_start beats an address strobe, which beats everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      code_mem_rd_addr   <= '0;
      code_mem_rd_en     <= 1'b0;
      inst_high_value    <= '0;
      inst_low_value     <= '0;
      readback_valid     <= 1'b0;
      readback_underflow <= 1'b0;
      high_done          <= 1'b0;
      low_done           <= 1'b0;
      pipe               <= '0;
    end else if (control_start) begin
      state            <= ST_IDLE;
      code_mem_rd_addr <= '0;
      code_mem_rd_en   <= 1'b0;
      readback_valid   <= 1'b0;
      high_done        <= 1'b0;
      low_done         <= 1'b0;
      pipe             <= '0;
    end else if (readback_addr_strobe) begin
      // Restart: any read already in flight is dropped by clearing the pipe.
      state              <= ST_FETCH;
      code_mem_rd_addr   <= readback_addr_value;
      code_mem_rd_en     <= 1'b1;
      readback_valid     <= 1'b0;
      readback_underflow <= 1'b0;
      high_done          <= 1'b0;
      low_done           <= 1'b0;
      pipe               <= '0;
    end else begin
      code_mem_rd_en <= 1'b0;
      pipe           <= pipe_shift[RD_LATENCY-1:0];
      if (any_rd && (state != ST_VALID)) begin
        readback_underflow <= 1'b1;
      end
      case (state)
        ST_FETCH: begin
          if (pipe_tail) begin
            inst_high_value <= code_mem_rd_data[63:32];
            inst_low_value  <= code_mem_rd_data[31:0];
            readback_valid  <= 1'b1;
            state           <= ST_FETCH + 2'd1;
          end
        end
        ST_VALID: begin
          if (both_done) begin
            code_mem_rd_addr <= code_mem_rd_addr + ADDR_ONE;
            code_mem_rd_en   <= 1'b1;
            readback_valid   <= 1'b0;
            high_done        <= 1'b0;
            low_done         <= 1'b0;
            state            <= ST_FETCH;
          end else begin
            high_done <= high_next;
            low_done  <= low_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regstrb2mem_readback.sv
// Bench for regstrb2mem_readback: two instances (RD_LATENCY 1 and 3) share one
// set of host inputs, each with its own code-memory model. Directed vector
// table, hand sequences for restart/control/reset, randomized word runs.
module tb_regstrb2mem_readback;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr_value;
  logic          addr_strobe;
  logic          hi_stb;
  logic          lo_stb;
  logic          ctrl;

  logic [AW-1:0] d1_addr, d3_addr;
  logic          d1_en, d3_en;
  logic [63:0]   d1_rdata, d3_rdata;
  logic [31:0]   d1_hi, d1_lo, d3_hi, d3_lo;
  logic          d1_valid, d3_valid, d1_uf, d3_uf;
  logic [1:0]    d1_state, d3_state;
  logic [63:0]   m3_pipe [3];

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  regstrb2mem_readback #(.CODE_ADDR_WIDTH(AW), .CODE_DATA_WIDTH(64), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .code_mem_rd_addr(d1_addr), .code_mem_rd_en(d1_en), .code_mem_rd_data(d1_rdata),
    .readback_addr_value(addr_value), .readback_addr_strobe(addr_strobe),
    .inst_high_rd_strobe(hi_stb), .inst_low_rd_strobe(lo_stb),
    .inst_high_value(d1_hi), .inst_low_value(d1_lo),
    .readback_valid(d1_valid), .readback_underflow(d1_uf),
    .control_start(ctrl), .debug_state(d1_state)
  );

  regstrb2mem_readback #(.CODE_ADDR_WIDTH(AW), .CODE_DATA_WIDTH(64), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .code_mem_rd_addr(d3_addr), .code_mem_rd_en(d3_en), .code_mem_rd_data(d3_rdata),
    .readback_addr_value(addr_value), .readback_addr_strobe(addr_strobe),
    .inst_high_rd_strobe(hi_stb), .inst_low_rd_strobe(lo_stb),
    .inst_high_value(d3_hi), .inst_low_value(d3_lo),
    .readback_valid(d3_valid), .readback_underflow(d3_uf),
    .control_start(ctrl), .debug_state(d3_state)
  );

  // Memory contents: word[a] = AAAA_<a> : BBBB_<a>
  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    return {16'hAAAA, 6'b0, a, 16'hBBBB, 6'b0, a};
  endfunction

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code memory models; cycles without a read return a poison pattern
  always @(posedge clk) begin
    d1_rdata   <= d1_en ? mem_word(d1_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    m3_pipe[0] <= d3_en ? mem_word(d3_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    m3_pipe[1] <= m3_pipe[0];
    m3_pipe[2] <= m3_pipe[1];
  end
  assign d3_rdata = m3_pipe[2];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector table
  typedef struct {
    logic          as;
    logic [AW-1:0] av;
    logic          hs;
    logic          ls;
    logic [AW-1:0] e_addr;
    logic          e_en;
    logic          e_valid;
    logic          e_uf;
    logic [63:0]   e_word;
  } vec_t;

  function automatic vec_t mk(input logic as, input logic [AW-1:0] av, input logic hs,
                              input logic ls, input logic [AW-1:0] e_addr, input logic e_en,
                              input logic e_valid, input logic e_uf, input logic [63:0] e_word);
    vec_t v;
    v.as = as; v.av = av; v.hs = hs; v.ls = ls;
    v.e_addr = e_addr; v.e_en = e_en; v.e_valid = e_valid; v.e_uf = e_uf; v.e_word = e_word;
    return v;
  endfunction

  // Waits for both instances to present valid after a trigger set at the
  // current negedge; checks latency (2+L cycles) and exactly one rd_en.
  task automatic wait_both();
    int seen1 = 0;
    int seen3 = 0;
    int en1 = 0;
    int en3 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        addr_strobe = 1'b0; hi_stb = 1'b0; lo_stb = 1'b0;
      end
      en1 += int'(d1_en);
      en3 += int'(d3_en);
      if (seen1 == 0 && d1_valid) seen1 = k;
      if (seen3 == 0 && d3_valid) seen3 = k;
      if (seen1 != 0 && seen3 != 0) break;
    end
    chk("lat1_valid", 64'(seen1), 64'd3);
    chk("lat3_valid", 64'(seen3), 64'd5);
    chk("rd_en_count1", 64'(en1), 64'd1);
    chk("rd_en_count3", 64'(en3), 64'd1);
  endtask

  // Read n words starting at start; mode 0 = both halves together,
  // 1 = low then high, 2 = high then low (first half repeated).
  task automatic run_words(input int start, input int n, input int mode);
    logic [AW-1:0] a;
    int dup;
    int gap;
    addr_value  = AW'(start);
    addr_strobe = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(AW'((start + i) % 1024));
    wait_both();
    for (int i = 0; i < n; i++) begin
      a = exp_q.pop_front();
      chk("word_addr1", 64'(d1_addr), 64'(a));
      chk("word_data1", {d1_hi, d1_lo}, mem_word(a));
      chk("word_addr3", 64'(d3_addr), 64'(a));
      chk("word_data3", {d3_hi, d3_lo}, mem_word(a));
      chk("no_underflow", {d1_uf, d3_uf}, 64'd0);
      if (mode == 0) begin
        hi_stb = 1'b1; lo_stb = 1'b1;
      end else begin
        dup = $urandom_range(1, 3);
        gap = $urandom_range(0, 2);
        for (int d = 0; d < dup; d++) begin
          if (mode == 1) lo_stb = 1'b1; else hi_stb = 1'b1;
          tick();
        end
        lo_stb = 1'b0; hi_stb = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        chk("half_read_holds", {d1_valid, d3_valid, d1_addr, d3_addr},
            {1'b1, 1'b1, a, a});
        if (mode == 1) hi_stb = 1'b1; else lo_stb = 1'b1;
      end
      wait_both();
    end
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {d1_addr, d1_en, d1_hi, d1_lo, d1_valid, d1_uf}, 64'd0);
    chk(name, {d3_addr, d3_en, d3_hi, d3_lo, d3_valid, d3_uf}, 64'd0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vec_t vecs[17];

  initial begin
    vecs[0]  = mk(1, 10'd5,    0, 0, 10'd5,    1, 0, 0, 64'h0);
    vecs[1]  = mk(0, 10'd0,    0, 0, 10'd5,    0, 0, 0, 64'h0);
    vecs[2]  = mk(0, 10'd0,    0, 0, 10'd5,    0, 1, 0, 64'hAAAA0005_BBBB0005);
    vecs[3]  = mk(0, 10'd0,    0, 1, 10'd5,    0, 1, 0, 64'hAAAA0005_BBBB0005);
    vecs[4]  = mk(0, 10'd0,    0, 1, 10'd5,    0, 1, 0, 64'hAAAA0005_BBBB0005);
    vecs[5]  = mk(0, 10'd0,    0, 1, 10'd5,    0, 1, 0, 64'hAAAA0005_BBBB0005);
    vecs[6]  = mk(0, 10'd0,    1, 0, 10'd6,    1, 0, 0, 64'hAAAA0005_BBBB0005);
    vecs[7]  = mk(0, 10'd0,    0, 0, 10'd6,    0, 0, 0, 64'hAAAA0005_BBBB0005);
    vecs[8]  = mk(0, 10'd0,    0, 0, 10'd6,    0, 1, 0, 64'hAAAA0006_BBBB0006);
    vecs[9]  = mk(0, 10'd0,    1, 1, 10'd7,    1, 0, 0, 64'hAAAA0006_BBBB0006);
    vecs[10] = mk(0, 10'd0,    1, 0, 10'd7,    0, 0, 1, 64'hAAAA0006_BBBB0006);
    vecs[11] = mk(0, 10'd0,    0, 0, 10'd7,    0, 1, 1, 64'hAAAA0007_BBBB0007);
    vecs[12] = mk(1, 10'd1021, 0, 1, 10'd1021, 1, 0, 0, 64'hAAAA0007_BBBB0007);
    vecs[13] = mk(0, 10'd0,    0, 0, 10'd1021, 0, 0, 0, 64'hAAAA0007_BBBB0007);
    vecs[14] = mk(0, 10'd0,    0, 0, 10'd1021, 0, 1, 0, 64'hAAAA03FD_BBBB03FD);
    vecs[15] = mk(0, 10'd0,    1, 0, 10'd1021, 0, 1, 0, 64'hAAAA03FD_BBBB03FD);
    vecs[16] = mk(0, 10'd0,    0, 1, 10'd1022, 1, 0, 0, 64'hAAAA03FD_BBBB03FD);

    // Reset
    rst_n = 1'b0; addr_value = '0; addr_strobe = 1'b0;
    hi_stb = 1'b0; lo_stb = 1'b0; ctrl = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    tick();

    // Directed vector table against the RD_LATENCY=1 instance
    for (int i = 0; i < 17; i++) begin
      addr_strobe = vecs[i].as; addr_value = vecs[i].av;
      hi_stb = vecs[i].hs; lo_stb = vecs[i].ls;
      tick();
      chk($sformatf("vec%0d_addr", i), 64'(d1_addr), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d_en", i), 64'(d1_en), 64'(vecs[i].e_en));
      chk($sformatf("vec%0d_valid", i), 64'(d1_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_uf", i), 64'(d1_uf), 64'(vecs[i].e_uf));
      chk($sformatf("vec%0d_word", i), {d1_hi, d1_lo}, vecs[i].e_word);
    end
    addr_strobe = 1'b0; hi_stb = 1'b0; lo_stb = 1'b0;

    // Wrap-around run: 1021, 1022, 1023, 0 read low then high
    run_words(1021, 4, 1);

    // Randomized word runs, biased toward the top of memory
    for (int t = 0; t < 8; t++) begin
      int start;
      start = ($urandom_range(0, 1) == 1) ? (1019 + $urandom_range(0, 4)) : $urandom_range(0, 1023);
      run_words(start, $urandom_range(1, 4), $urandom_range(0, 2));
    end

    // Restart mid-fetch: strobe 10, then 20 two cycles later
    addr_value = 10'd10; addr_strobe = 1'b1;
    tick();
    addr_strobe = 1'b0;
    tick();
    addr_value = 10'd20; addr_strobe = 1'b1;
    begin
      int en3 = 0;
      for (int k = 1; k <= 5; k++) begin
        tick();
        if (k == 1) begin
          addr_strobe = 1'b0;
          chk("restart_addr3", {d3_en, d3_addr}, {1'b1, 10'd20});
          chk("restart_addr1", {d1_en, d1_addr}, {1'b1, 10'd20});
        end
        en3 += int'(d3_en);
        chk($sformatf("restart_valid3_k%0d", k), 64'(d3_valid), (k == 5) ? 64'd1 : 64'd0);
        if (k <= 3)
          chk($sformatf("restart_valid1_k%0d", k), 64'(d1_valid), (k == 3) ? 64'd1 : 64'd0);
        if (k == 3) chk("restart_data1", {d1_hi, d1_lo}, mem_word(10'd20));
      end
      chk("restart_data3", {d3_hi, d3_lo}, mem_word(10'd20));
      chk("restart_rd_en3", 64'(en3), 64'd1);
    end

    // control_start while VALID
    addr_value = 10'd30; addr_strobe = 1'b1;
    wait_both();
    chk("ctrl_pre_valid", {d1_valid, d3_valid}, 64'd3);
    ctrl = 1'b1;
    tick();
    chk("ctrl_cut1", {d1_valid, d1_en, d1_addr}, 64'd0);
    chk("ctrl_cut3", {d3_valid, d3_en, d3_addr}, 64'd0);
    addr_value = 10'd40; addr_strobe = 1'b1; hi_stb = 1'b1;
    tick();
    chk("ctrl_ignore1", {d1_valid, d1_en, d1_addr, d1_uf}, 64'd0);
    chk("ctrl_ignore3", {d3_valid, d3_en, d3_addr, d3_uf}, 64'd0);
    ctrl = 1'b0; addr_strobe = 1'b0; hi_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ctrl_release_idle", {d1_valid, d1_en, d3_valid, d3_en}, 64'd0);
    end
    hi_stb = 1'b1;
    tick();
    hi_stb = 1'b0;
    chk("idle_underflow", {d1_uf, d3_uf}, 64'd3);

    // Asynchronous reset mid-FETCH
    addr_value = 10'd50; addr_strobe = 1'b1;
    tick();
    addr_strobe = 1'b0;
    chk("pre_reset_fetch", {d1_en, d1_addr}, {1'b1, 10'd50});
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_all_zero("post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
